// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared state encodings and default sizing for mem_responder
package mem_resp_pkg;

  localparam int DEPTH_WORDS_DEF = 256;
  localparam int LATENCY_DEF     = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_resp_ram.sv
// rtl/mem_resp_ram.sv - single-port synchronous 32-bit RAM with write enable and registered read
module mem_resp_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage is deliberately left out of reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register only updates on a read so the last value is held between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder with abort detection and transaction counters
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_req,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] abort_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rd_count_q, rd_count_d;
  logic [31:0]   wr_count_q, wr_count_d;
  logic [31:0]   abort_count_q, abort_count_d;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_re;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[31:AW];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    rd_count_d    = rd_count_q;
    wr_count_d    = wr_count_q;
    abort_count_d = abort_count_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          addr_d  = mem_addr[AW-1:0];
          write_d = mem_write;
          wdata_d = mem_wdata;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!mem_req) begin
          abort_count_d = abort_count_q + 32'd1;
          state_d       = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (write_q) begin
          wr_count_d = wr_count_q + 32'd1;
        end else begin
          rd_count_d = rd_count_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      rd_count_q    <= '0;
      wr_count_q    <= '0;
      abort_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
      abort_count_q <= abort_count_d;
    end
  end

  // With LATENCY=1 the read is issued on the accepting edge, before addr_q is loaded.
  assign ram_addr = (state_q == ST_IDLE) ? mem_addr[AW-1:0] : addr_q;
  assign ram_we   = (state_q == ST_RESP) && write_q;
  assign ram_re   = (state_d == ST_RESP) && (state_q != ST_RESP) && !write_d;

  mem_resp_ram #(
    .DEPTH(DEPTH_WORDS),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  assign mem_ready   = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign abort_count = abort_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed scoreboard bench for mem_responder at LATENCY 4 and 1
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic        req_i   [2];
  logic        write_i [2];
  logic [31:0] rdata_o [2];
  logic        ready_o [2];
  logic        busy_o  [2];
  logic [31:0] rdc     [2];
  logic [31:0] wrc     [2];
  logic [31:0] abc     [2];

  logic [31:0] model [2][256];
  logic [31:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr_i[0]), .mem_wdata(wdata_i[0]),
    .mem_req(req_i[0]), .mem_write(write_i[0]), .mem_rdata(rdata_o[0]),
    .mem_ready(ready_o[0]), .busy(busy_o[0]), .rd_count(rdc[0]),
    .wr_count(wrc[0]), .abort_count(abc[0])
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr_i[1]), .mem_wdata(wdata_i[1]),
    .mem_req(req_i[1]), .mem_write(write_i[1]), .mem_rdata(rdata_o[1]),
    .mem_ready(ready_o[1]), .busy(busy_o[1]), .rd_count(rdc[1]),
    .wr_count(wrc[1]), .abort_count(abc[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; optionally moves mem_addr to a2 right after acceptance.
  task automatic txn(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic chg, input logic [31:0] a2);
    int n;
    logic [31:0] prev;
    logic [31:0] e;
    @(negedge clk);
    prev = rdata_o[s];
    req_i[s] = 1'b1; write_i[s] = wr; addr_i[s] = a; wdata_i[s] = d;
    if (!wr) exp_q.push_back(model[s][a[7:0]]);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (chg && n == 1) addr_i[s] = a2;
    end while (!ready_o[s] && n < 40);
    check("ready_seen", {31'd0, ready_o[s]}, 32'd1);
    check("latency", n, (s == 0) ? 32'd4 : 32'd1);
    if (!wr) begin
      e = exp_q.pop_front();
      check("read_data", rdata_o[s], e);
    end else begin
      check("rdata_hold_on_write", rdata_o[s], prev);
    end
    @(negedge clk);
    req_i[s] = 1'b0;
    @(posedge clk); #1;
    check("ready_single_pulse", {31'd0, ready_o[s]}, 32'd0);
    check("idle_after_resp", {31'd0, busy_o[s]}, 32'd0);
    if (wr) model[s][a[7:0]] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      addr_i[i] = '0; wdata_i[i] = '0; req_i[i] = 1'b0; write_i[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", {31'd0, ready_o[i]}, 32'd0);
      check("rst_busy", {31'd0, busy_o[i]}, 32'd0);
      check("rst_rdata", rdata_o[i], 32'd0);
      check("rst_rd_count", rdc[i], 32'd0);
      check("rst_wr_count", wrc[i], 32'd0);
      check("rst_abort_count", abc[i], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read at LATENCY 4
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    check("r033_data", rdata_o[0], 32'hDEADBEEF);
    check("r033_wr_count", wrc[0], 32'd1);
    check("r033_rd_count", rdc[0], 32'd1);

    // LATENCY 1 back-to-back: write 0x5 then read 0x6 with req held high
    txn(1, 1'b1, 32'h6, 32'h66666666, 1'b0, 32'h0);
    @(negedge clk);
    req_i[1] = 1'b1; write_i[1] = 1'b1; addr_i[1] = 32'h5; wdata_i[1] = 32'h11111111;
    @(posedge clk); #1;
    check("b2b_first_ready", {31'd0, ready_o[1]}, 32'd1);
    @(negedge clk);
    write_i[1] = 1'b0; addr_i[1] = 32'h6;
    @(posedge clk); #1;
    check("b2b_gap_ready", {31'd0, ready_o[1]}, 32'd0);
    check("b2b_gap_busy", {31'd0, busy_o[1]}, 32'd0);
    @(posedge clk); #1;
    check("b2b_second_ready", {31'd0, ready_o[1]}, 32'd1);
    check("b2b_second_data", rdata_o[1], model[1][6]);
    @(negedge clk);
    req_i[1] = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_ready", {31'd0, ready_o[1]}, 32'd0);
    model[1][5] = 32'h11111111;
    check("b2b_wr_count", wrc[1], 32'd2);
    check("b2b_rd_count", rdc[1], 32'd1);
    txn(1, 1'b0, 32'h5, 32'h0, 1'b0, 32'h0);

    // Abort a write after two WAIT cycles
    txn(0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, 32'h0);
    @(negedge clk);
    req_i[0] = 1'b1; write_i[0] = 1'b1; addr_i[0] = 32'h20; wdata_i[0] = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_ready", {31'd0, ready_o[0]}, 32'd0);
      check("abort_busy", {31'd0, busy_o[0]}, 32'd1);
    end
    @(negedge clk);
    req_i[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_final_ready", {31'd0, ready_o[0]}, 32'd0);
    check("abort_idle", {31'd0, busy_o[0]}, 32'd0);
    check("abort_count", abc[0], 32'd1);
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

    // Address aliasing modulo 256
    txn(0, 1'b1, 32'h103, 32'hA5A5A5A5, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h03, 32'h0, 1'b0, 32'h0);
    check("alias_data", rdata_o[0], 32'hA5A5A5A5);

    // Address change after acceptance is ignored
    txn(0, 1'b1, 32'h7, 32'h77777777, 1'b0, 32'h0);
    txn(0, 1'b1, 32'h8, 32'h88888888, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h7, 32'h0, 1'b1, 32'h8);
    check("addr_change_data", rdata_o[0], 32'h77777777);

    // Reset during WAIT of a write
    txn(0, 1'b1, 32'h30, 32'h30303030, 1'b0, 32'h0);
    @(negedge clk);
    req_i[0] = 1'b1; write_i[0] = 1'b1; addr_i[0] = 32'h30; wdata_i[0] = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready_o[0]}, 32'd0);
    check("midrst_busy", {31'd0, busy_o[0]}, 32'd0);
    check("midrst_rdata", rdata_o[0], 32'd0);
    check("midrst_rd_count", rdc[0], 32'd0);
    check("midrst_wr_count", wrc[0], 32'd0);
    check("midrst_abort_count", abc[0], 32'd0);
    req_i[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0);
    check("midrst_preserved", rdata_o[0], 32'h30303030);
    check("midrst_abort_not_counted", abc[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, meaning number of 32-bit words in the backing store (power of two, >= 2).
REQ-002 SHALL provide parameter LATENCY, default 4, meaning clock edges from request acceptance to mem_ready (range 1..15).
REQ-003 SHALL provide port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port mem_addr  input  32  word address from the cache.
REQ-006 SHALL provide port mem_wdata  input  32  write data.
REQ-007 SHALL provide port mem_req  input  1  request valid; held high until mem_ready.
REQ-008 SHALL provide port mem_write  input  1  1 = write, 0 = read.
REQ-009 SHALL provide port mem_rdata  output  32  read data, valid while mem_ready is high on a read.
REQ-010 SHALL provide port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL provide ports rd_count, wr_count, abort_count  output  32 each  completed reads, completed writes, aborted requests.

Function
REQ-013 SHALL use FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: on an edge with mem_req=1, SHALL latch mem_addr[log2(DEPTH_WORDS)-1:0], mem_write and mem_wdata, then go to RESP if LATENCY=1, else go to WAIT with the down-counter loaded with LATENCY-2.
REQ-015 Address bits above log2(DEPTH_WORDS) SHALL be ignored, so addresses alias modulo DEPTH_WORDS.
REQ-016 WAIT: if mem_req=0 at an edge, SHALL increment abort_count, perform no array access, and go to IDLE.
REQ-017 WAIT: otherwise, if the counter equals 0, SHALL go to RESP; else SHALL decrement the counter.
REQ-018 Changes on mem_addr, mem_wdata or mem_write after acceptance SHALL be ignored.
REQ-019 mem_ready SHALL be 1 exactly during the single RESP cycle, which is LATENCY edges after the accepting edge, and 0 otherwise.
REQ-020 Read: mem_rdata SHALL be registered on the edge entering RESP with array[latched addr]; SHALL increment rd_count on the edge leaving RESP.
REQ-021 Write: array[latched addr] SHALL be written with latched wdata on the edge leaving RESP; SHALL increment wr_count on that edge; mem_rdata SHALL hold its previous value.
REQ-022 After a write completes, any later read of the same address SHALL return the new data.
REQ-023 RESP SHALL always complete and go to IDLE, regardless of mem_req.
REQ-024 A request still high in the cycle after RESP (cache going WRITEBACK to ALLOCATE) SHALL be accepted by IDLE at the next edge as a new transaction, giving one idle cycle between transactions.
REQ-025 mem_rdata SHALL hold its last value between transactions.
REQ-026 All counters SHALL wrap modulo 2^32.
REQ-027 busy SHALL be combinational from state.

Reset
REQ-028 When rst_n=0, SHALL asynchronously force state=IDLE, mem_ready=0, mem_rdata=0, busy=0, counter=0 and rd_count, wr_count, abort_count = 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no array write and no abort_count increment.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 SHALL place the state enum (IDLE, WAIT, RESP) and default DEPTH_WORDS/LATENCY constants in a shared package mem_resp_pkg.
REQ-032 SHALL implement the backing store in one sub-module mem_resp_ram: a single-port synchronous RAM, 32-bit words, DEPTH_WORDS deep, with write enable and registered read.

Verification
REQ-033 LATENCY=4: write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> mem_ready exactly 4 edges after each accept; read returns 0xDEADBEEF; wr_count=1, rd_count=1.
REQ-034 LATENCY=1: write 0x11111111 to addr 0x5, keep mem_req high, switch mem_write to 0 and mem_addr to 0x6 in the mem_ready cycle -> second transaction accepted after one idle cycle; both complete.
REQ-035 Drop mem_req after 2 cycles of WAIT (LATENCY=4) on a write of 0xCAFEF00D to 0x20 -> no mem_ready; abort_count=1; a subsequent read of 0x20 returns the prior contents.
REQ-036 Write 0xA5A5A5A5 to addr 0x103 with DEPTH_WORDS=256 -> a read of addr 0x03 returns 0xA5A5A5A5.
REQ-037 Change mem_addr from 0x7 to 0x8 during WAIT of a read -> data returned from 0x7.
REQ-038 Assert rst_n=0 during WAIT of a write of 0x12345678 to 0x30 -> outputs and counters zero, and a read of 0x30 after reset returns the pre-reset value.
